apb_master_cmd: RTL and testbench
=================================

# apb_master_cmd

Single-outstanding APB master that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers for the peripheral cores (apb_gpio and siblings). It sits directly upstream of the peripheral, generating `psel`, `penable`, `paddr`, `pwrite` and `pwdata`, and honouring `pready`. It returns read data and completion status on a one-cycle response strobe.

## Interface
- `ADDR_WIDTH`, 4: width of `cmd_addr` and `paddr`.
- `DATA_WIDTH`, 8: width of write/read data.
- `TIMEOUT_CYCLES`, 16: maximum ACCESS cycles with `pready` low before abort (≥1; used only with timeout compiled in).

Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- `pclk`  in  1  clock; all logic on rising edge.
- `preset`  in  1  asynchronous active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  master can accept a command; high only in IDLE and not in reset.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  target register address.
- `cmd_wdata`  in  DATA_WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle completion strobe.
- `rsp_rdata`  out  DATA_WIDTH  captured `prdata` for reads; 0 for writes and errors.
- `rsp_err`  out  1  transfer aborted by timeout; qualified by `rsp_valid`.
- `busy`  out  1  high in SETUP or ACCESS.
- `psel`, `penable`, `pwrite`  out  1 each  APB control.
- `paddr`  out  ADDR_WIDTH;  `pwdata`  out  DATA_WIDTH  APB address and write data.
- `prdata`  in  DATA_WIDTH;  `pready`  in  1  APB slave read data and ready.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, register `cmd_write/addr/wdata` into `pwrite/paddr/pwdata` and go to SETUP.
- SETUP: `psel`=1, `penable`=0; unconditionally go to ACCESS.
- ACCESS: `psel`=1, `penable`=1. When `pready`=1, capture `prdata` into `rsp_rdata` (reads only, else 0) and go to IDLE; `rsp_valid`=1 during the first IDLE cycle.
- `paddr`, `pwrite`, `pwdata` stay stable from SETUP through the end of ACCESS and hold their last values in IDLE.
- No response backpressure: the consumer must accept `rsp_valid` when it fires.
- `cmd_*` inputs are sampled only on the accepting edge; changes afterwards have no effect on the transfer in flight.
- Reset mid-transfer: all outputs go to reset values immediately (async), the FSM goes to IDLE, and no response is issued.
- Reset values: `psel`=`penable`=`pwrite`=0, `paddr`=`pwdata`=0, `rsp_valid`=`rsp_err`=0, `rsp_rdata`=0, `busy`=0, `cmd_ready`=0. `cmd_ready` rises combinationally once `preset` deasserts.

## Timing
- Accept at edge N → SETUP during N..N+1 → ACCESS from edge N+1.
- With zero wait states, `pready`=1 is sampled at edge N+2 and `rsp_valid` is high during N+2..N+3.
- Each cycle of `pready`=0 in ACCESS adds one cycle.
- Minimum command-to-command spacing is 3 cycles: a new command may be accepted in the same IDLE cycle that shows `rsp_valid`.
- `cmd_ready` is combinational from state (and `preset`); all other outputs are registered.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined: a counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with `pready`=0.
  - When the counter reaches TIMEOUT_CYCLES with `pready` still 0, the master deasserts `psel`/`penable`, returns to IDLE, and issues `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0.
  - If `pready`=1 on the same edge the limit is reached, the transfer completes normally.
- Not defined: no counter; ACCESS waits indefinitely; `rsp_err` is tied 0.

## Test plan
- Reset and accept: assert `preset` for 10 cycles, then release → all outputs 0 during reset; `cmd_ready`=1 after release. Send write addr 2, data 0xAA → SETUP cycle with `psel`=1, `penable`=0, `paddr`=2, `pwdata`=0xAA, then ACCESS; with `pready`=1, `rsp_valid` pulses 1 cycle, `rsp_err`=0.
- Back-to-back writes: addr 0 data 0xFF, then addr 1 data 0xFF, then addr 1 data 0x00, each presented in the IDLE cycle showing `rsp_valid` → accepted with 3-cycle spacing; APB fields stable through each ACCESS.
- Read with wait states: read addr 3, slave holds `pready`=0 for 4 cycles, `prdata`=0x34 → ACCESS lasts 5 cycles; `rsp_rdata`=0x34, `rsp_err`=0.
- Timeout (macro on, TIMEOUT_CYCLES=16): read with `pready` held 0 → abort after 16 ACCESS cycles; `rsp_err`=1, `rsp_rdata`=0, `psel`=0. Same stimulus with the macro off → still in ACCESS after 100 cycles.
- Reset mid-ACCESS: assert `preset` during a wait-stated write → `psel`/`penable` drop immediately; no `rsp_valid`; next command after release behaves normally.
- Input change after accept: change `cmd_addr` and `cmd_wdata` one cycle after acceptance → `paddr`/`pwdata` keep the accepted values.

Source files
------------

// File: rtl/apb_master_cmd_if.sv
// ============================================================================
// Module   : apb_master_cmd_if
// Purpose  : Command/response and APB bus signals for apb_master_cmd.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_master_cmd_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;

   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   logic                  busy;

   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
             psel, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
             psel, penable, pwrite, paddr, pwdata
   );
endinterface

`default_nettype wire

// File: rtl/apb_master_cmd.sv
// ============================================================================
// Module   : apb_master_cmd
// Purpose  : Single-outstanding APB master driven by a valid/ready command port.
//            Define APB_MASTER_TIMEOUT_EN to abort stalled ACCESS phases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_cmd #(
   parameter int ADDR_WIDTH     = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  wire logic        pclk,
   input  wire logic        preset,
   apb_master_cmd_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  psel_q, penable_q, pwrite_q;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic [DATA_WIDTH-1:0] pwdata_q;
   logic                  rsp_valid_q, rsp_err_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;

   logic                  w_accept;
   logic                  w_done;
   logic                  w_timeout;

   assign bus.cmd_ready = (state_q == S_IDLE) && !preset;
   assign w_accept      = bus.cmd_valid && bus.cmd_ready;
   assign w_done        = (state_q == S_ACCESS) && bus.pready;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter holds the number of stalled ACCESS cycles already elapsed.
   always_comb begin
      cnt_d     = cnt_q;
      w_timeout = 1'b0;
      if (state_q == S_SETUP) begin
         cnt_d = '0;
      end else if ((state_q == S_ACCESS) && !bus.pready) begin
         if (cnt_q == CNT_LAST) begin
            w_timeout = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
   assign w_timeout        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (w_accept) state_d = S_SETUP;
         S_SETUP:  state_d = S_ACCESS;
         S_ACCESS: if (w_done || w_timeout) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q     <= S_IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         psel_q    <= (state_d != S_IDLE);
         penable_q <= (state_d == S_ACCESS);
         if (w_accept) begin
            pwrite_q <= bus.cmd_write;
            paddr_q  <= bus.cmd_addr;
            pwdata_q <= bus.cmd_wdata;
         end
         rsp_valid_q <= w_done || w_timeout;
         rsp_err_q   <= w_timeout;
         rsp_rdata_q <= (w_done && !pwrite_q) ? bus.prdata : '0;
      end
   end

   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.busy      = psel_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_cmd.sv
// ============================================================================
// Module   : tb_apb_master_cmd
// Purpose  : Randomised scoreboard bench for apb_master_cmd with an APB slave model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master_cmd;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int TO = 16;
`ifdef APB_MASTER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   typedef struct {
      logic [DW-1:0] rdata;
      bit            err;
      int            lat;
      int            acc;
   } rsp_t;

   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] pdata;
      int            waits;
   } xfer_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   int    cyc = 0;
   int    n_pass = 0;
   int    n_total = 0;
   rsp_t  sb_q[$];
   xfer_t slv_q[$];
   xfer_t cur;
   bit    in_xfer = 1'b0;
   int    acc_cnt = 0;
   int    last_acc = 0;

   apb_master_cmd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

   apb_master_cmd #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .pclk  (clk),
      .preset(rst),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
   endtask

   // Reference: W low-pready cycles cost W+2 edges; a stall of TO cycles aborts at TO+1.
   function automatic rsp_t model(input xfer_t x, input int acc);
      rsp_t r;
      r.err   = TO_EN && (x.waits >= TO);
      r.lat   = r.err ? TO + 1 : x.waits + 2;
      r.rdata = (!x.wr && !r.err) ? x.pdata : '0;
      r.acc   = acc;
      return r;
   endfunction

   // APB slave model plus per-cycle protocol and field-stability checks
   always @(negedge clk) begin
      if (rst) begin
         in_xfer    = 1'b0;
         bus.pready = 1'b0;
      end else if (bus.psel) begin
         if (!in_xfer) begin
            chk("setup_penable", 32'(bus.penable), 32'd0);
            chk("setup_has_cmd", 32'(slv_q.size() != 0), 32'd1);
            if (slv_q.size() != 0) cur = slv_q.pop_front();
            in_xfer    = 1'b1;
            acc_cnt    = 0;
            bus.pready = 1'b0;
            bus.prdata = DW'($urandom);
         end else begin
            chk("access_penable", 32'(bus.penable), 32'd1);
            bus.pready = (acc_cnt >= cur.waits);
            bus.prdata = bus.pready ? cur.pdata : DW'($urandom);
            acc_cnt++;
         end
         chk("paddr",  32'(bus.paddr),  32'(cur.addr));
         chk("pwrite", 32'(bus.pwrite), 32'(cur.wr));
         chk("pwdata", 32'(bus.pwdata), 32'(cur.wdata));
      end else begin
         in_xfer    = 1'b0;
         bus.pready = 1'b0;
      end
   end

   // Response monitor: pops the scoreboard whenever the DUT strobes rsp_valid
   always @(negedge clk) begin
      rsp_t e;
      if (!rst && bus.rsp_valid) begin
         chk("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("rsp_rdata",   32'(bus.rsp_rdata), 32'(e.rdata));
            chk("rsp_err",     32'(bus.rsp_err),   32'(e.err));
            chk("rsp_latency", 32'(cyc - e.acc),   32'(e.lat));
         end
      end
   end

   task automatic send(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] pd, input int waits);
      xfer_t x;
      int    n;
      x = '{wr, a, d, pd, waits};
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      n = 0;
      while (!bus.cmd_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("accept_in_time", 32'(n < 400), 32'd1);
      if (n < 400) begin
         last_acc = cyc + 1;
         sb_q.push_back(model(x, last_acc));
         slv_q.push_back(x);
      end
      @(posedge clk);
   endtask

   // Drops valid and scrambles the command fields the cycle after acceptance
   task automatic idle();
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = AW'($urandom);
      bus.cmd_wdata = DW'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || bus.busy || bus.rsp_valid) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain_in_time", 32'(n < 400), 32'd1);
   endtask

   initial begin
      int    a0, a1, a2;
      xfer_t xs;
      rsp_t  rs;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.pready    = 1'b0;
      bus.prdata    = '0;

      repeat (10) @(negedge clk);
      chk("rst_psel",      32'(bus.psel),      32'd0);
      chk("rst_penable",   32'(bus.penable),   32'd0);
      chk("rst_pwrite",    32'(bus.pwrite),    32'd0);
      chk("rst_paddr",     32'(bus.paddr),     32'd0);
      chk("rst_pwdata",    32'(bus.pwdata),    32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
      chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("cmd_ready_after_rst", 32'(bus.cmd_ready), 32'd1);

      send(1'b1, 4'd2, 8'hAA, 8'h00, 0);
      idle();
      drain();

      send(1'b1, 4'd0, 8'hFF, 8'h00, 0);
      a0 = last_acc;
      send(1'b1, 4'd1, 8'hFF, 8'h00, 0);
      a1 = last_acc;
      send(1'b1, 4'd1, 8'h00, 8'h00, 0);
      a2 = last_acc;
      idle();
      drain();
      chk("b2b_spacing_1", 32'(a1 - a0), 32'd3);
      chk("b2b_spacing_2", 32'(a2 - a1), 32'd3);

      send(1'b0, 4'd3, 8'h5C, 8'h34, 4);
      idle();
      drain();

      send(1'b0, 4'd5, 8'h00, 8'h77, TO - 1);
      idle();
      drain();
      send(1'b0, 4'd6, 8'h00, 8'h88, TO);
      idle();
      drain();

      xs = '{1'b0, 4'd3, 8'h00, 8'h9D, 105};
      send(xs.wr, xs.addr, xs.wdata, xs.pdata, xs.waits);
      a0 = last_acc;
      rs = model(xs, a0);
      idle();
      while (cyc < a0 + 100) @(negedge clk);
      chk("stalled_at_100", 32'(bus.psel && bus.penable), 32'(rs.lat > 100));
      drain();

      send(1'b1, 4'd4, 8'h3C, 8'h00, 10);
      idle();
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_psel",    32'(bus.psel),    32'd0);
      chk("midrst_penable", 32'(bus.penable), 32'd0);
      chk("midrst_paddr",   32'(bus.paddr),   32'd0);
      chk("midrst_pwdata",  32'(bus.pwdata),  32'd0);
      chk("midrst_ready",   32'(bus.cmd_ready), 32'd0);
      sb_q.delete();
      slv_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      send(1'b1, 4'd7, 8'h5A, 8'h00, 1);
      idle();
      drain();

      for (int i = 0; i < 40; i++) begin
         send(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 2)));
         if ($urandom_range(0, 1) == 1) begin
            idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      idle();
      drain();
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
